// File: rtl/serial_pkg.sv
// serial_pkg: encodings and frame constants shared by both ends of the 1-bit serial link.
package serial_pkg;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_DATA   = 3'd1;
  localparam logic [2:0] S_PARITY = 3'd2;
  localparam logic [2:0] S_STOP   = 3'd3;
  localparam logic [2:0] S_BREAK  = 3'd4;

  // start + 7 data + parity + stop
  localparam int FRAME_BITS = 10;
  // 1: total ones over data and parity must be odd
  localparam bit PARITY_ODD = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE   = S_IDLE,
    ST_DATA   = S_DATA,
    ST_PARITY = S_PARITY,
    ST_STOP   = S_STOP,
    ST_BREAK  = S_BREAK
  } state_t;

endpackage

// File: rtl/serial_receiver.sv
// serial_receiver: deframes the LSB-first serial link, checks parity and stop bit,
// and holds each word for the consumer until it is acknowledged.
//
//  state  | meaning
//  IDLE   | line idle, waiting for a start bit (0)
//  DATA   | sampling payload bits d0..d(DATA_W-1)
//  PARITY | sampling the parity bit
//  STOP   | sampling the stop bit; the frame is committed on this edge
//  BREAK  | stop bit was 0; waiting for the line to return high
module serial_receiver
  import serial_pkg::*;
#(
  parameter int DATA_W = FRAME_BITS - 3
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              serial_in,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  input  logic              data_ack,
  output logic              parity_err,
  output logic              frame_err,
  output logic              overrun,
  output logic              busy
);

  localparam int               CNT_W    = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  state_t            r_state;
  logic [CNT_W-1:0]  r_bit_cnt;
  logic [DATA_W-1:0] r_shreg;
  logic [DATA_W-1:0] r_data;
  logic              r_par;
  logic              r_valid;
  logic              r_perr;
  logic              r_ferr;
  logic              r_ovr;
  logic              r_busy;

  // Deframing FSM plus commit and consumer handshake; every output is registered here.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state   <= ST_IDLE;
      r_bit_cnt <= '0;
      r_shreg   <= '0;
      r_data    <= '0;
      r_par     <= 1'b0;
      r_valid   <= 1'b0;
      r_perr    <= 1'b0;
      r_ferr    <= 1'b0;
      r_ovr     <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      // An ack drops valid; a commit on the same edge overrides it below.
      if (data_ack && r_valid) r_valid <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (!serial_in) begin
            r_state   <= ST_DATA;
            r_bit_cnt <= '0;
            r_busy    <= 1'b1;
          end
        end
        ST_DATA: begin
          r_shreg[r_bit_cnt] <= serial_in;
          if (r_bit_cnt == LAST_BIT) r_state <= ST_PARITY;
          else                       r_bit_cnt <= r_bit_cnt + 1'b1;
        end
        ST_PARITY: begin
          r_par   <= serial_in;
          r_state <= ST_STOP;
        end
        ST_STOP: begin
          // Errors are reported alongside the word, never instead of it.
          r_data  <= r_shreg;
          r_perr  <= (^{r_par, r_shreg}) != PARITY_ODD;
          r_ferr  <= ~serial_in;
          r_valid <= 1'b1;
          if (r_valid && !data_ack) r_ovr <= 1'b1;
          if (serial_in) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_state <= ST_BREAK;
          end
        end
        ST_BREAK: begin
          // A stuck-low line must not be deframed as a run of zero frames.
          if (serial_in) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign data_out   = r_data;
  assign data_valid = r_valid;
  assign parity_err = r_perr;
  assign frame_err  = r_ferr;
  assign overrun    = r_ovr;
  assign busy       = r_busy;

endmodule

// File: tb/tb_serial_receiver.sv
// tb_serial_receiver: directed frames against a frame-level model, checked every cycle,
// plus literal expectations at the interesting points of each scenario.
module tb_serial_receiver;

  logic       clk;
  logic       rstn;
  logic       serial_in;
  logic [6:0] data_out;
  logic       data_valid;
  logic       data_ack;
  logic       parity_err;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  bit cmp_en = 0;

  serial_receiver #(.DATA_W(7)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .serial_in  (serial_in),
    .data_out   (data_out),
    .data_valid (data_valid),
    .data_ack   (data_ack),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge counter used for latency measurements.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  // ---------------- frame-level model ----------------
  // Collects the line samples of one frame into an array and evaluates the
  // frame as a whole once all ten samples are in.
  logic [9:0] m_bits;
  int         m_n;
  bit         m_brk;
  logic [6:0] m_data;
  bit         m_valid, m_perr, m_ferr, m_ovr, m_busy;
  int         c_cyc[$];
  logic [6:0] c_dat[$];

  // Advance the model on each edge, then compare the DUT against it just after the edge.
  always @(posedge clk) begin
    bit commit;
    commit = 0;
    if (!rstn) begin
      m_n = 0; m_brk = 0; m_bits = '0; m_data = '0;
      m_valid = 0; m_perr = 0; m_ferr = 0; m_ovr = 0;
    end else begin
      if (m_brk) begin
        if (serial_in) m_brk = 0;
      end else if (m_n == 0) begin
        if (!serial_in) begin
          m_bits = '0;
          m_n = 1;
        end
      end else begin
        m_bits[m_n] = serial_in;
        m_n++;
        if (m_n == 10) begin
          commit = 1;
          m_n = 0;
          m_brk = !serial_in;
        end
      end
      if (commit) begin
        if (m_valid && !data_ack) m_ovr = 1;
        m_valid = 1;
        m_data  = m_bits[7:1];
        m_perr  = ($countones(m_bits[8:1]) % 2) == 0;
        m_ferr  = !m_bits[9];
        c_cyc.push_back(cyc + 1);
        c_dat.push_back(m_bits[7:1]);
      end else if (m_valid && data_ack) begin
        m_valid = 0;
      end
    end
    m_busy = m_brk || (m_n != 0);
    #1;
    if (cmp_en) begin
      chk("cyc_data_out",   {25'd0, data_out}, {25'd0, m_data});
      chk("cyc_data_valid", {31'd0, data_valid}, {31'd0, m_valid});
      chk("cyc_parity_err", {31'd0, parity_err}, {31'd0, m_perr});
      chk("cyc_frame_err",  {31'd0, frame_err}, {31'd0, m_ferr});
      chk("cyc_overrun",    {31'd0, overrun}, {31'd0, m_ovr});
      chk("cyc_busy",       {31'd0, busy}, {31'd0, m_busy});
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive_bit(input logic b);
    @(negedge clk);
    serial_in = b;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      serial_in = 1'b1;
      data_ack  = 1'b0;
    end
  endtask

  task automatic ack_once();
    @(negedge clk);
    data_ack = 1'b1;
    @(negedge clk);
    data_ack = 1'b0;
  endtask

  // Drives one frame; ack_last raises data_ack together with the stop bit.
  task automatic send(input logic [6:0] d, input logic bad_par, input logic stop,
                      input logic ack_last, output int t_start);
    logic p;
    p = (~^d) ^ bad_par;
    @(negedge clk);
    serial_in = 1'b0;
    t_start = cyc;
    for (int i = 0; i < 7; i++) drive_bit(d[i]);
    drive_bit(p);
    @(negedge clk);
    serial_in = stop;
    if (ack_last) data_ack = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int t0, t1, nc;
    rstn = 1'b0; serial_in = 1'b1; data_ack = 1'b0;
    @(negedge clk);
    cmp_en = 1;
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    chk("rst_outputs", {data_out, data_valid, parity_err, frame_err, overrun, busy}, 12'h000);
    idle(2);

    // 1: 0x55 good frame, ack in valid cycle
    send(7'h55, 1'b0, 1'b1, 1'b0, t0);
    @(posedge clk); #1;
    chk("t1_latency", cyc - t0, 10);
    chk("t1_valid", {31'd0, data_valid}, 1);
    chk("t1_data", {25'd0, data_out}, 32'h55);
    chk("t1_errs", {30'd0, parity_err, frame_err}, 0);
    ack_once();
    chk("t1_acked", {31'd0, data_valid}, 0);
    idle(2);

    // 2: 0x00 then 0x7F back to back, first word acked in its valid cycle
    nc = c_dat.size();
    fork
      begin
        send(7'h00, 1'b0, 1'b1, 1'b0, t0);
        send(7'h7F, 1'b0, 1'b1, 1'b0, t1);
      end
      begin
        repeat (11) @(negedge clk);
        data_ack = 1'b1;
        @(negedge clk);
        data_ack = 1'b0;
      end
    join
    @(posedge clk); #1;
    chk("t2_commits", c_dat.size() - nc, 2);
    if (c_dat.size() >= nc + 2) begin
      chk("t2_first", {25'd0, c_dat[nc]}, 32'h00);
      chk("t2_second", {25'd0, c_dat[nc+1]}, 32'h7F);
      chk("t2_spacing", c_cyc[nc+1] - c_cyc[nc], 10);
    end
    chk("t2_data", {25'd0, data_out}, 32'h7F);
    chk("t2_flags", {29'd0, parity_err, frame_err, overrun}, 0);
    ack_once();
    idle(2);

    // 3: 0x55 with wrong parity bit (0)
    send(7'h55, 1'b1, 1'b1, 1'b0, t0);
    @(posedge clk); #1;
    chk("t3_data", {25'd0, data_out}, 32'h55);
    chk("t3_perr", {31'd0, parity_err}, 1);
    chk("t3_ferr", {31'd0, frame_err}, 0);
    ack_once();
    idle(2);

    // 4: stop bit 0, line held low for 20 more clocks, then released
    nc = c_dat.size();
    send(7'h33, 1'b0, 1'b0, 1'b0, t0);
    for (int i = 0; i < 20; i++) drive_bit(1'b0);
    @(posedge clk); #1;
    chk("t4_ferr", {31'd0, frame_err}, 1);
    chk("t4_data", {25'd0, data_out}, 32'h33);
    chk("t4_busy_break", {31'd0, busy}, 1);
    chk("t4_one_commit", c_dat.size() - nc, 1);
    drive_bit(1'b1);
    @(posedge clk); #1;
    chk("t4_idle", {31'd0, busy}, 0);
    ack_once();
    idle(2);

    // 5a: two frames without ack -> overrun
    send(7'h12, 1'b0, 1'b1, 1'b0, t0);
    idle(1);
    send(7'h6B, 1'b0, 1'b1, 1'b0, t1);
    @(posedge clk); #1;
    chk("t5_data", {25'd0, data_out}, 32'h6B);
    chk("t5_overrun", {31'd0, overrun}, 1);
    idle(3);
    chk("t5_sticky", {31'd0, overrun}, 1);
    // 5b: after reset, ack on the exact commit edge of the second frame
    @(negedge clk); rstn = 1'b0;
    @(negedge clk); rstn = 1'b1;
    idle(1);
    send(7'h21, 1'b0, 1'b1, 1'b0, t0);
    idle(1);
    send(7'h4E, 1'b0, 1'b1, 1'b1, t1);
    @(posedge clk); #1;
    chk("t5b_valid", {31'd0, data_valid}, 1);
    chk("t5b_overrun", {31'd0, overrun}, 0);
    chk("t5b_data", {25'd0, data_out}, 32'h4E);
    idle(2);

    // 6: reset at the d3 sample of a frame (word 0x4E still pending)
    drive_bit(1'b0);
    drive_bit(1'b1); drive_bit(1'b0); drive_bit(1'b1);
    @(negedge clk); rstn = 1'b0; serial_in = 1'b0;
    @(posedge clk); #1;
    chk("t6_rst_outputs", {data_out, data_valid, parity_err, frame_err, overrun, busy}, 12'h000);
    @(negedge clk); rstn = 1'b1; serial_in = 1'b1;
    idle(12);
    chk("t6_no_commit", {31'd0, data_valid}, 0);
    send(7'h2C, 1'b0, 1'b1, 1'b0, t0);
    @(posedge clk); #1;
    chk("t6_data", {25'd0, data_out}, 32'h2C);
    chk("t6_valid", {31'd0, data_valid}, 1);
    chk("t6_errs", {29'd0, parity_err, frame_err, overrun}, 0);
    idle(3);

    cmp_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
